prio_enc_arb: RTL and testbench
===============================

PRIO_ENC_ARB -- requirements
Module: prio_enc_arb

Interface
REQ-001 Parameter N, default 8, number of request lines (N >= 2).
REQ-002 Parameter W, default 3, index width, SHALL equal clog2(N).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  N  request lines; bit i = line i.
REQ-006 mode  input  1  0 = fixed priority (highest index wins); 1 = round-robin.
REQ-007 out_ready  input  1  consumer accepts current grant.
REQ-008 out_valid  output  1  registered grant valid.
REQ-009 out_idx  output  W  encoded index of granted line.
REQ-010 out_onehot  output  N  one-hot of out_idx.
REQ-011 out_multi  output  1  more than one req bit was set when the grant was captured.

Function
REQ-012 Two states SHALL exist: IDLE (out_valid=0) and HOLD (out_valid=1).
REQ-013 Fixed mode: the winner SHALL be the highest set index of req.
REQ-014 Round-robin mode: the search SHALL start at index (last-1) mod N and descend with wrap (0 -> N-1); the first set bit wins. last = index of the most recently accepted grant.
REQ-015 IDLE with req != 0 at an edge: winner SHALL be registered into out_idx/out_onehot/out_multi and state SHALL go to HOLD, giving out_valid=1 one cycle after req is sampled.
REQ-016 IDLE with req == 0: state SHALL remain IDLE; outputs SHALL keep their values and out_valid SHALL stay 0.
REQ-017 HOLD with out_ready=0: out_idx, out_onehot and out_multi SHALL hold stable, even if req changes or drops to zero.
REQ-018 HOLD with out_ready=1 (handshake): last SHALL load out_idx.
REQ-019 On handshake with req != 0: the next winner SHALL be computed using the updated last (i.e. pointer = accepted out_idx), SHALL be registered the same edge, and state SHALL stay HOLD (back-to-back, one grant per cycle).
REQ-020 On handshake with req == 0: state SHALL go to IDLE and out_valid SHALL drop the next cycle.
REQ-021 mode SHALL be sampled only when a winner is captured; a change during HOLD SHALL NOT alter the held grant.
REQ-022 last SHALL update only on handshake, never on capture alone; mode=0 handshakes still update last.
REQ-023 out_multi SHALL be 1 iff popcount(req) >= 2 at capture.
REQ-024 out_onehot SHALL always equal 1 << out_idx, including after reset.
REQ-025 out_ready while in IDLE SHALL be ignored.

Reset
REQ-026 rst=1 SHALL immediately, without clock, force state IDLE, out_valid=0, out_idx=0, out_onehot=1, out_multi=0, last=0.
REQ-027 last=0 after reset SHALL make the first round-robin search start at N-1, identical to fixed priority.
REQ-028 Reset asserted in HOLD SHALL discard the pending grant; no handshake SHALL be recorded.
REQ-029 After rst release, the first capture SHALL occur at the first rising edge with req != 0.

Verification (N=8)
REQ-030 Fixed: mode=0, req=8'b0010_0110, out_ready=1 -> next cycle out_valid=1, out_idx=5, out_onehot=8'h20, out_multi=1.
REQ-031 Round-robin: mode=1, req=8'hFF held, out_ready=1 -> out_idx sequence 7,6,5,4,3,2,1,0,7 on consecutive cycles, out_valid continuously 1.
REQ-032 Backpressure: capture idx 3 with out_ready=0, then change req to 8'h80 for 4 cycles -> out_idx stays 3, out_valid stays 1; on out_ready=1, next out_idx=7.
REQ-033 Drain: single req=8'h01 for one cycle, out_ready=1 -> out_valid high exactly one cycle, out_idx=0, out_multi=0, then IDLE.
REQ-034 Async reset: assert rst mid-cycle while in HOLD with out_idx=6 -> out_valid=0, out_idx=0, out_onehot=8'h01 before next edge; with mode=1, req=8'h41 after release -> out_idx=6.
REQ-035 Mode switch: mode 1->0 during HOLD -> held grant unchanged; next capture with req=8'h81 -> out_idx=7 regardless of last.

Source files
------------

// File: rtl/prio_enc_arb.sv
// Priority-encoding arbiter with a registered grant and valid/ready handshake.
// In fixed mode the highest set request index wins. In round-robin mode the search
// starts just below the last accepted index and wraps. A grant stays frozen
// until it is accepted.
module prio_enc_arb #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot,
    output logic         out_multi
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] last;
    logic [W-1:0] ptr;
    logic [W-1:0] winner;
    logic         capture;
    logic         handshake;

    // Highest set index of r. Returns 0 when r is empty, but the result is unused then.
    function automatic logic [W-1:0] fixed_pick(input logic [N-1:0] r);
        logic [W-1:0] pick;
        pick = '0;
        for (int j = 0; j < N; j++) begin
            if (r[j]) pick = W'(j);
        end
        return pick;
    endfunction

    // First set index found while descending from (p-1) mod N with wrap-around.
    function automatic logic [W-1:0] rr_pick(input logic [N-1:0] r, input logic [W-1:0] p);
        logic [W-1:0] pick;
        logic         found;
        int           k;
        pick  = '0;
        found = 1'b0;
        for (int j = 0; j < N; j++) begin
            k = (int'(p) + 2 * N - 1 - j) % N;
            if (!found && r[k]) begin
                pick  = W'(k);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Next-state logic and capture/handshake decode.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        handshake = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    handshake = 1'b1;
                    if (|req) capture = 1'b1;
                    else state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Winner selection. On a back-to-back handshake the search pivots on the grant
    // that is being accepted on this edge, not on the stale pointer.
    always_comb begin
        ptr    = handshake ? out_idx : last;
        winner = mode ? rr_pick(req, ptr) : fixed_pick(req);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Grant registers and round-robin pointer. The pointer moves only on acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_idx    <= '0;
            out_onehot <= ONE;
            out_multi  <= 1'b0;
            last       <= '0;
        end else begin
            if (handshake) last <= out_idx;
            if (capture) begin
                out_idx    <= winner;
                out_onehot <= ONE << winner;
                out_multi  <= ($countones(req) > 1);
            end
        end
    end

    assign out_valid = (state == HOLD);

endmodule

// File: tb/tb_prio_enc_arb.sv
// Bench for prio_enc_arb (N=8): directed vector table, hand-written corner
// sequences and a randomized run against a behavioural reference model.
module tb_prio_enc_arb;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic         mode;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_idx;
    logic [N-1:0] out_onehot;
    logic         out_multi;

    int passed = 0;
    int total  = 0;

    prio_enc_arb #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .mode       (mode),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .out_onehot (out_onehot),
        .out_multi  (out_multi)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] req;
        bit         mode;
        bit         rdy;
        bit         v;
        int         idx;
        bit         multi;
    } vec_t;

    vec_t tbl[14];

    // reference model state
    bit m_valid;
    int m_idx;
    bit m_multi;
    int m_last;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_outs(input string tag, input bit v, input int idx, input bit multi);
        logic [7:0] oh;
        oh = 8'd1 << idx;
        check({tag, ".valid"},  int'(out_valid),  int'(v));
        check({tag, ".idx"},    int'(out_idx),    idx);
        check({tag, ".onehot"}, int'(out_onehot), int'(oh));
        check({tag, ".multi"},  int'(out_multi),  int'(multi));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_idx   = 0;
        m_multi = 1'b0;
        m_last  = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    function automatic int ref_winner(input logic [7:0] r, input bit m, input int p);
        if (!m) begin
            for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (p - k + 2 * N) % N;
                if (r[i]) return i;
            end
        end
        return 0;
    endfunction

    function automatic int popcnt(input logic [7:0] r);
        int c;
        c = 0;
        for (int i = 0; i < N; i++) c += int'(r[i]);
        return c;
    endfunction

    // Advance the model by one clock edge using the current inputs.
    task automatic model_step();
        bit do_cap;
        do_cap = 1'b0;
        if (!m_valid) begin
            do_cap = (req != 0);
        end else if (out_ready) begin
            m_last = m_idx;
            if (req != 0) do_cap = 1'b1;
            else m_valid = 1'b0;
        end
        if (do_cap) begin
            m_idx   = ref_winner(req, mode, m_last);
            m_multi = (popcnt(req) >= 2);
            m_valid = 1'b1;
        end
    endtask

    initial begin
        tbl[0]  = '{8'h26, 1'b0, 1'b1, 1'b1, 5, 1'b1};
        tbl[1]  = '{8'h00, 1'b0, 1'b1, 1'b0, 5, 1'b1};
        tbl[2]  = '{8'hFF, 1'b1, 1'b1, 1'b1, 4, 1'b1};
        tbl[3]  = '{8'hFF, 1'b1, 1'b1, 1'b1, 3, 1'b1};
        tbl[4]  = '{8'h80, 1'b1, 1'b0, 1'b1, 3, 1'b1};
        tbl[5]  = '{8'h80, 1'b1, 1'b0, 1'b1, 3, 1'b1};
        tbl[6]  = '{8'h80, 1'b1, 1'b1, 1'b1, 7, 1'b0};
        tbl[7]  = '{8'h01, 1'b1, 1'b1, 1'b1, 0, 1'b0};
        tbl[8]  = '{8'h00, 1'b1, 1'b1, 1'b0, 0, 1'b0};
        tbl[9]  = '{8'h00, 1'b0, 1'b1, 1'b0, 0, 1'b0};
        tbl[10] = '{8'h41, 1'b1, 1'b0, 1'b1, 6, 1'b1};
        tbl[11] = '{8'h41, 1'b0, 1'b0, 1'b1, 6, 1'b1};
        tbl[12] = '{8'h81, 1'b0, 1'b1, 1'b1, 7, 1'b1};
        tbl[13] = '{8'h00, 1'b0, 1'b1, 1'b0, 7, 1'b1};

        rst       = 1'b1;
        req       = '0;
        mode      = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #3;
        check_outs("reset", 1'b0, 0, 1'b0);
        tick();
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 14; i++) begin
            req       = tbl[i].req;
            mode      = tbl[i].mode;
            out_ready = tbl[i].rdy;
            tick();
            check_outs($sformatf("tbl%0d", i), tbl[i].v, tbl[i].idx, tbl[i].multi);
        end

        // Round-robin sweep with everything requesting
        do_reset();
        req = 8'hFF; mode = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            check_outs($sformatf("rr%0d", i), 1'b1, (15 - i) % 8, 1'b1);
        end

        // Drain: one single-bit request
        do_reset();
        req = 8'h01; mode = 1'b0; out_ready = 1'b1;
        tick();
        check_outs("drain0", 1'b1, 0, 1'b0);
        req = 8'h00;
        tick();
        check_outs("drain1", 1'b0, 0, 1'b0);
        tick();
        check_outs("drain2", 1'b0, 0, 1'b0);

        // Asynchronous reset while holding idx 6
        do_reset();
        req = 8'h40; mode = 1'b0; out_ready = 1'b0;
        tick();
        check_outs("hold6", 1'b1, 6, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_outs("arst", 1'b0, 0, 1'b0);
        rst = 1'b0;
        model_reset();
        req = 8'h41; mode = 1'b1;
        tick();
        check_outs("post_arst", 1'b1, 6, 1'b1);

        // Randomized run against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            if ($urandom_range(0, 3) == 0) req = '0;
            else if ($urandom_range(0, 1) == 0) req = 8'd1 << $urandom_range(0, 7);
            else req = 8'($urandom) & 8'($urandom);
            mode      = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            model_step();
            tick();
            check_outs($sformatf("rnd%0d", c), m_valid, m_idx, m_multi);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
